// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - request/response bus between the memory arbiter and the data-memory responder
interface data_memory_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_funct3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output mem_addr, mem_write_data, mem_funct3, mem_read, mem_write,
    input  mem_read_data, mem_ready, mem_error
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_funct3, mem_read, mem_write,
    output mem_read_data, mem_ready, mem_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - single-port data memory with wait states, RISC-V sized loads/stores and error reporting
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic                    clk,
  input logic                    rst,
  data_memory_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_rd;
  logic        req_wr;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live inputs are evaluated so a zero-wait request can respond right away.
  logic [31:0] ev_addr;
  logic [31:0] ev_wdata;
  logic [2:0]  ev_funct3;
  logic        ev_rd;
  logic        ev_wr;
  logic        ev_in_range;
  logic [AW-1:0] ev_idx;
  logic [31:0] ev_word;
  logic [31:0] ev_shifted;
  logic [31:0] ev_rdata;
  logic        ev_load_ok;
  logic        ev_store_ok;
  logic        ev_misaligned;
  logic        ev_err;
  logic [3:0]  ev_be;
  logic [31:0] ev_wlanes;
  logic        go_resp;

  always_comb begin
    if (state == IDLE) begin
      ev_addr   = bus.mem_addr;
      ev_wdata  = bus.mem_write_data;
      ev_funct3 = bus.mem_funct3;
      ev_rd     = bus.mem_read;
      ev_wr     = bus.mem_write;
    end else begin
      ev_addr   = req_addr;
      ev_wdata  = req_wdata;
      ev_funct3 = req_funct3;
      ev_rd     = req_rd;
      ev_wr     = req_wr;
    end
  end

  always_comb begin
    ev_in_range   = ({2'b00, ev_addr[31:2]} < 32'(DEPTH_WORDS));
    ev_idx        = ev_in_range ? ev_addr[AW+1:2] : '0;
    ev_word       = mem[ev_idx];
    ev_shifted    = ev_word >> {ev_addr[1:0], 3'b000};
    ev_load_ok    = (ev_funct3 == 3'b000) || (ev_funct3 == 3'b001) || (ev_funct3 == 3'b010) ||
                    (ev_funct3 == 3'b100) || (ev_funct3 == 3'b101);
    ev_store_ok   = (ev_funct3 == 3'b000) || (ev_funct3 == 3'b001) || (ev_funct3 == 3'b010);
    ev_misaligned = ((ev_funct3[1:0] == 2'b01) && ev_addr[0]) ||
                    ((ev_funct3[1:0] == 2'b10) && (ev_addr[1:0] != 2'b00));
    ev_err        = (ev_rd && ev_wr) || (ev_rd && !ev_load_ok) || (ev_wr && !ev_store_ok) ||
                    ev_misaligned || !ev_in_range;
  end

  always_comb begin
    ev_rdata = 32'h0;
    case (ev_funct3)
      3'b000:  ev_rdata = {{24{ev_shifted[7]}}, ev_shifted[7:0]};
      3'b001:  ev_rdata = {{16{ev_shifted[15]}}, ev_shifted[15:0]};
      3'b010:  ev_rdata = ev_word;
      3'b100:  ev_rdata = {24'h0, ev_shifted[7:0]};
      3'b101:  ev_rdata = {16'h0, ev_shifted[15:0]};
      default: ev_rdata = 32'h0;
    endcase
  end

  always_comb begin
    ev_be     = 4'b0000;
    ev_wlanes = ev_wdata;
    case (ev_funct3[1:0])
      2'b00: begin
        ev_be     = 4'b0001 << ev_addr[1:0];
        ev_wlanes = {4{ev_wdata[7:0]}};
      end
      2'b01: begin
        ev_be     = ev_addr[1] ? 4'b1100 : 4'b0011;
        ev_wlanes = {2{ev_wdata[15:0]}};
      end
      2'b10: begin
        ev_be     = 4'b1111;
        ev_wlanes = ev_wdata;
      end
      default: begin
        ev_be     = 4'b0000;
        ev_wlanes = ev_wdata;
      end
    endcase
  end

  always_comb begin
    go_resp = ((state == IDLE) && (bus.mem_read || bus.mem_write) && (WAIT_CYCLES == 0)) ||
              ((state == WAIT) && (cnt == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      req_addr          <= 32'h0;
      req_wdata         <= 32'h0;
      req_funct3        <= 3'b000;
      req_rd            <= 1'b0;
      req_wr            <= 1'b0;
      bus.mem_ready     <= 1'b0;
      bus.mem_error     <= 1'b0;
      bus.mem_read_data <= 32'h0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            req_addr   <= bus.mem_addr;
            req_wdata  <= bus.mem_write_data;
            req_funct3 <= bus.mem_funct3;
            req_rd     <= bus.mem_read;
            req_wr     <= bus.mem_write;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A legal store leaves the previous load result on the bus.
      if (go_resp) begin
        bus.mem_ready <= 1'b1;
        bus.mem_error <= ev_err;
        if (ev_err) begin
          bus.mem_read_data <= 32'h0;
        end else if (ev_rd) begin
          bus.mem_read_data <= ev_rdata;
        end
      end
    end
  end

  // Stores commit at the edge that closes RESP; reset on that edge cancels them.
  always_ff @(posedge clk) begin
    if (!rst && (state == RESP) && ev_wr && !ev_err) begin
      for (int i = 0; i < 4; i++) begin
        if (ev_be[i]) begin
          mem[ev_idx][8*i +: 8] <= ev_wlanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized self-checking bench for data_memory_responder
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 1;
  localparam int LAT   = WAITC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_last = 32'h0;

  data_memory_responder_if bus ();

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the access rules written directly as byte arithmetic on a word array.
  task automatic ref_access(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] wd, output logic e, output logic [31:0] d);
    int size;
    int lane;
    logic [31:0] w, v, mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lane = int'(a[1:0]);
    e = 1'b0;
    if (rd && wr) e = 1'b1;
    if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) e = 1'b1;
    if (wr && f3 > 3'd2) e = 1'b1;
    if ((a % size) != 0) e = 1'b1;
    if ((a / 4) >= DEPTH) e = 1'b1;
    if (e) begin
      d = 32'h0;
    end else if (rd) begin
      w    = model_mem[a[11:2]];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      v    = (w >> (8 * lane)) & mask;
      if (f3[2] == 1'b0 && size < 4 && v[8*size-1]) v = v | ~mask;
      d = v;
    end else begin
      for (int i = 0; i < size; i++) model_mem[a[11:2]][8*(lane+i) +: 8] = wd[8*i +: 8];
      d = model_last;
    end
    model_last = d;
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] d, output logic e, output int lat);
    int k;
    @(negedge clk);
    bus.mem_addr       = a;
    bus.mem_write_data = wd;
    bus.mem_funct3     = f3;
    bus.mem_read       = rd;
    bus.mem_write      = wr;
    @(posedge clk);
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    lat = -1;
    d   = 32'hx;
    e   = 1'bx;
    k   = 1;
    while (lat < 0 && k <= 20) begin
      if (bus.mem_ready) begin
        lat = k;
        d   = bus.mem_read_data;
        e   = bus.mem_error;
      end else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_addr = 32'h0; bus.mem_write_data = 32'h0; bus.mem_funct3 = 3'b0;
    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_ready !== 1'b0) $display("FAIL reset_ready cyc %0d: got %b want 0", i, bus.mem_ready);
      else passed++;
      total++;
      if (bus.mem_error !== 1'b0) $display("FAIL reset_error cyc %0d: got %b want 0", i, bus.mem_error);
      else passed++;
      total++;
      if (bus.mem_read_data !== 32'h0) $display("FAIL reset_rdata cyc %0d: got %h want 0", i, bus.mem_read_data);
      else passed++;
    end
    model_last = 32'h0;
  endtask

  task automatic test_store_load();
    logic [31:0] d, ed; logic e, ee; int lat;
    do_req(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, d, e, lat);
    ref_access(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, ee, ed);
    total++;
    if (lat !== LAT) $display("FAIL sw_latency: got %0d want %0d", lat, LAT);
    else passed++;
    total++;
    if (e !== 1'b0) $display("FAIL sw_error: got %b want 0", e);
    else passed++;
    do_req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, d, e, lat);
    ref_access(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, ee, ed);
    total++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0)
      $display("FAIL lw_after_sw: got %h err %b want deadbeef err 0", d, e);
    else passed++;
  endtask

  task automatic test_byte_half();
    logic [31:0] d, ed; logic e, ee; int lat;
    logic [31:0] a_t [5];
    logic [2:0]  f_t [5];
    logic [31:0] x_t [5];
    a_t = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h12};
    f_t = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    x_t = '{32'h1234_8078, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234, 32'h0000_1234};
    do_req(1'b0, 1'b1, 32'h10, 3'b010, 32'h1234_5678, d, e, lat);
    ref_access(1'b0, 1'b1, 32'h10, 3'b010, 32'h1234_5678, ee, ed);
    do_req(1'b0, 1'b1, 32'h11, 3'b000, 32'hFFFF_FF80, d, e, lat);
    ref_access(1'b0, 1'b1, 32'h11, 3'b000, 32'hFFFF_FF80, ee, ed);
    total++;
    if (e !== 1'b0 || d !== 32'hDEAD_BEEF)
      $display("FAIL sb_response: got data %h err %b want deadbeef err 0", d, e);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 1'b0, a_t[i], f_t[i], 32'h0, d, e, lat);
      ref_access(1'b1, 1'b0, a_t[i], f_t[i], 32'h0, ee, ed);
      total++;
      if (d !== x_t[i] || e !== 1'b0)
        $display("FAIL sized_load f3=%b addr=%h: got %h err %b want %h err 0", f_t[i], a_t[i], d, e, x_t[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] d, ed; logic e, ee; int lat;
    logic        r_t [5];
    logic        w_t [5];
    logic [31:0] a_t [5];
    logic [2:0]  f_t [5];
    r_t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    w_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    a_t = '{32'h13, 32'h01, 32'h10, 32'h10, DEPTH * 4};
    f_t = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b010};
    do_req(1'b0, 1'b1, 32'h0, 3'b010, 32'hCAFE_F00D, d, e, lat);
    ref_access(1'b0, 1'b1, 32'h0, 3'b010, 32'hCAFE_F00D, ee, ed);
    for (int i = 0; i < 5; i++) begin
      do_req(r_t[i], w_t[i], a_t[i], f_t[i], 32'h5555_AAAA, d, e, lat);
      ref_access(r_t[i], w_t[i], a_t[i], f_t[i], 32'h5555_AAAA, ee, ed);
      total++;
      if (e !== 1'b1 || d !== 32'h0 || lat !== LAT)
        $display("FAIL error_case %0d: got err %b data %h lat %0d want err 1 data 0 lat %0d", i, e, d, lat, LAT);
      else passed++;
    end
    do_req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, d, e, lat);
    ref_access(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, ee, ed);
    total++;
    if (d !== 32'h1234_8078) $display("FAIL error_nowrite_10: got %h want 12348078", d);
    else passed++;
    do_req(1'b1, 1'b0, 32'h0, 3'b010, 32'h0, d, e, lat);
    ref_access(1'b1, 1'b0, 32'h0, 3'b010, 32'h0, ee, ed);
    total++;
    if (d !== 32'hCAFE_F00D) $display("FAIL error_nowrite_00: got %h want cafef00d", d);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] d, ed, a, wd; logic e, ee, rd, wr; logic [2:0] f3; int lat, sel;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_req(1'b0, 1'b1, 32'(i * 4), 3'b010, wd, d, e, lat);
      ref_access(1'b0, 1'b1, 32'(i * 4), 3'b010, wd, ee, ed);
    end
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel == 0) || (sel < 6);
      wr  = (sel == 0) || (sel >= 6);
      f3  = 3'($urandom_range(0, 7));
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else if (sel == 1) a = $urandom | 32'h8000_0000;
      else               a = 32'($urandom_range(0, 63));
      do_req(rd, wr, a, f3, wd, d, e, lat);
      ref_access(rd, wr, a, f3, wd, ee, ed);
      total++;
      if (lat !== LAT || e !== ee || d !== ed)
        $display("FAIL random %0d rd=%b wr=%b f3=%b addr=%h: got lat %0d err %b data %h want lat %0d err %b data %h",
                 i, rd, wr, f3, a, lat, e, d, LAT, ee, ed);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic r [30];
    logic [31:0] ed; logic ee;
    int pulses, last, bad_gap, bad_data;
    ref_access(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, ee, ed);
    @(negedge clk);
    bus.mem_addr = 32'h10; bus.mem_funct3 = 3'b010; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    pulses = 0; last = -1; bad_gap = 0; bad_data = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      r[i] = bus.mem_ready;
      if (r[i] === 1'b1) begin
        if (bus.mem_read_data !== ed || bus.mem_error !== 1'b0) bad_data++;
        if (last >= 0 && (i - last) != WAITC + 2) bad_gap++;
        last = i;
        pulses++;
      end
      if (i > 0 && r[i] === 1'b1 && r[i-1] === 1'b1) bad_gap++;
    end
    bus.mem_read = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (pulses !== 10) $display("FAIL b2b_pulse_count: got %0d want 10", pulses);
    else passed++;
    total++;
    if (bad_gap !== 0) $display("FAIL b2b_spacing: got %0d bad gaps want 0", bad_gap);
    else passed++;
    total++;
    if (bad_data !== 0) $display("FAIL b2b_data: got %0d bad responses want 0", bad_data);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed, old; logic e, ee; int lat, seen;
    old = 32'hA5A5_0F0F;
    do_req(1'b0, 1'b1, 32'h20, 3'b010, old, d, e, lat);
    ref_access(1'b0, 1'b1, 32'h20, 3'b010, old, ee, ed);
    @(negedge clk);
    bus.mem_addr = 32'h20; bus.mem_write_data = 32'h1111_2222; bus.mem_funct3 = 3'b010;
    bus.mem_read = 1'b0;   bus.mem_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 32'h0;
    total++;
    if (bus.mem_read_data !== 32'h0) $display("FAIL rst_mid_rdata: got %h want 0", bus.mem_read_data);
    else passed++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_ready === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) $display("FAIL rst_mid_ready: got %0d pulses want 0", seen);
    else passed++;
    do_req(1'b1, 1'b0, 32'h20, 3'b010, 32'h0, d, e, lat);
    ref_access(1'b1, 1'b0, 32'h20, 3'b010, 32'h0, ee, ed);
    total++;
    if (d !== old || e !== 1'b0) $display("FAIL rst_mid_nostore: got %h err %b want %h err 0", d, e, old);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_half();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Shared data-memory responder that sits on the memory side of the dual-core memory arbiter and serves its single request port. It does the following:
- Accepts one load or store at a time.
- Models a configurable number of wait states.
- Applies RISC-V byte, halfword and word semantics, with load sign/zero extension and store byte-lane merging.
- Returns a one-cycle completion strobe, with an error flag for misaligned, out-of-range or malformed requests.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; legal word index range is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 1, wait states inserted between capture and response; legal range is 0..15.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_addr  in  32  byte address; word index = mem_addr[31:2].
- mem_write_data  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- mem_funct3  in  3  access size/sign, RISC-V load/store funct3 encoding.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- mem_read_data  out  32  formatted load result; registered and held until the next response.
- mem_ready  out  1  one-cycle completion strobe.
- mem_error  out  1  error flag; valid only while mem_ready=1.

## Operation
State machine states:
- IDLE
- WAIT
- RESP

Transitions:
- IDLE, with mem_read|mem_write high at a rising edge: capture addr, wdata, funct3, rd and wr into request registers. Go to WAIT with cnt=WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
- WAIT: decrement cnt each cycle. When cnt=0, go to RESP.
- RESP: hold for exactly one cycle with mem_ready=1, then return to IDLE.
- Inputs are ignored outside IDLE. A request still held high during RESP is recaptured in the following IDLE cycle.

Error checks are made on the captured request. An error sets mem_error=1 in RESP, suppresses any store, and drives mem_read_data=0. A request is an error if any of the following holds:
- rd and wr are both high.
- funct3 is not in {000, 001, 010, 100, 101} for a load.
- funct3 is not in {000, 001, 010} for a store.
- It is a halfword access with addr[0]=1.
- It is a word access with addr[1:0]!=0.
- The word index is >= DEPTH_WORDS.

Loads (word W = mem[addr[31:2]], lane selected by addr[1:0]):
- 000 LB: sign-extend byte.
- 001 LH: sign-extend halfword.
- 010 LW: the full word W.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend halfword.

Stores (committed at the rising edge that ends the RESP cycle, affected bytes only):
- 000 SB: write wdata[7:0] to byte lane addr[1:0].
- 001 SH: write wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
- 010 SW: write all four lanes.
- Other bytes of the word are unchanged.

Store-response outputs:
- mem_error is 0 if the store is legal.
- mem_read_data keeps its previous value.

Reset and memory contents:
- Reset values: state=IDLE, mem_ready=0, mem_error=0, mem_read_data=0.
- Memory array contents are not affected by reset.
- Reset asserted in WAIT or RESP drops the pending request: no store, no mem_ready.

## Timing
- Request sampled at edge E0. mem_ready is high during cycle E0+1+WAIT_CYCLES and never for longer than one cycle.
- The minimum issue interval is WAIT_CYCLES+2 cycles per request.
- Load data and mem_error become valid in the same cycle as mem_ready.
- mem_read_data is stable from that cycle until the next load response or reset.
- Read-after-write: a load captured after a store's RESP cycle returns the updated data.
- Errors incur the same latency as successful accesses.

## Test plan
All cases use WAIT_CYCLES=1.
- Reset, then idle: mem_ready, mem_error and mem_read_data are all 0 after reset deasserts and stay 0 for 10 cycles with no request.
- SW addr=0x10, data 0xDEADBEEF, then LW 0x10:
  - the store's mem_ready pulse comes 2 cycles after capture;
  - the load returns 0xDEADBEEF with mem_error=0.
- SB 0x80 to 0x11, then LB 0x11, LBU 0x11, LH 0x12 and LHU 0x12 (word 0x12345678 initialized by SW 0x10):
  - after the SB, the word at 0x10 is 0x12348078;
  - LB 0x11 returns 0xFFFFFF80;
  - LBU 0x11 returns 0x00000080;
  - LH 0x12 returns 0x00001234;
  - LHU 0x12 returns 0x00001234.
- LW 0x13, SH 0x01, funct3=011 load, rd+wr both high, and an address of DEPTH_WORDS*4: each gives mem_error=1 and mem_read_data=0; memory is unchanged, checked by a follow-up LW.
- mem_read held high continuously: mem_ready pulses every 3 cycles and is never high for 2 consecutive cycles.
- SW issued, then rst pulsed during the WAIT cycle: no mem_ready pulse; a subsequent LW of that address returns the old contents.
